// File: rtl/systolic_drain.sv
// systolic_drain
// Output end of the systolic matrix-multiply path. When the array reports
// that its results are final, the whole SIZE x SIZE accumulator matrix is
// captured in one cycle, saturated to OUT_WIDTH per element, and the array
// accumulators are told to clear. The captured matrix is then streamed to
// the downstream consumer one row per beat over a valid/ready handshake.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle pulse: array results are final
//   res_in     flattened accumulators, element [i][j] at (i*SIZE+j)*RESULT_WIDTH
//   acc_clear  one-cycle pulse clearing the array accumulators
//   busy       high while a matrix is held or streaming
//   out_valid  row beat valid
//   out_ready  consumer accepts the beat
//   out_data   row elements, column j at j*OUT_WIDTH
//   out_row    index of the row on out_data
//   out_last   high with the final row
//   overrun    sticky flag: a start arrived while streaming and was dropped
module systolic_drain #(
  parameter int SIZE         = 8,
  parameter int RESULT_WIDTH = 32,
  parameter int OUT_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [SIZE*SIZE*RESULT_WIDTH-1:0]   res_in,
  output logic                                acc_clear,
  output logic                                busy,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SIZE*OUT_WIDTH-1:0]           out_data,
  output logic [((SIZE>1)?$clog2(SIZE):1)-1:0] out_row,
  output logic                                out_last,
  output logic                                overrun
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                          stateQ, stateD;
  logic [ROW_W-1:0]                rowQ, rowD;
  logic [SIZE*SIZE*OUT_WIDTH-1:0]  bufQ, bufD;
  logic                            accClearQ, accClearD;
  logic                            overrunQ, overrunD;

  logic [SIZE*SIZE*OUT_WIDTH-1:0]  satSnap;
  logic [RESULT_WIDTH-1:0]         elem;
  logic [SIZE*OUT_WIDTH-1:0]       rowData;
  logic                            sending;
  logic                            atLastRow;
  logic                            beatXfer;
  logic                            lastXfer;
  logic                            accept;

  // Saturate every accumulator to OUT_WIDTH: any set bit above the output
  // width means the value does not fit, so clamp to all ones. With equal
  // widths the shift leaves nothing and this is a plain pass-through.
  always_comb begin
    satSnap = '0;
    elem    = '0;
    for (int k = 0; k < SIZE*SIZE; k++) begin
      elem = res_in[k*RESULT_WIDTH +: RESULT_WIDTH];
      if ((elem >> OUT_WIDTH) != '0) begin
        satSnap[k*OUT_WIDTH +: OUT_WIDTH] = '1;
      end else begin
        satSnap[k*OUT_WIDTH +: OUT_WIDTH] = elem[OUT_WIDTH-1:0];
      end
    end
  end

  // Select the current row out of the snapshot buffer.
  always_comb begin
    rowData = bufQ[int'(rowQ)*(SIZE*OUT_WIDTH) +: SIZE*OUT_WIDTH];
  end

  assign sending   = (stateQ == SEND);
  assign atLastRow = (rowQ == ROW_W'(SIZE-1));
  assign beatXfer  = sending & out_ready;
  assign lastXfer  = beatXfer & atLastRow;
  // A new matrix may land on the very cycle the final row leaves, giving
  // back-to-back streams with no idle bubble.
  assign accept    = start & (~sending | lastXfer);

  // Next-state logic: capture on accept, advance on each transfer, and
  // flag any start that arrives mid-stream without touching the stream.
  always_comb begin
    stateD    = stateQ;
    rowD      = rowQ;
    bufD      = bufQ;
    accClearD = 1'b0;
    overrunD  = overrunQ;
    if (accept) begin
      stateD    = SEND;
      rowD      = '0;
      bufD      = satSnap;
      accClearD = 1'b1;
    end else begin
      if (lastXfer) begin
        stateD = IDLE;
        rowD   = '0;
      end else if (beatXfer) begin
        rowD = rowQ + ROW_W'(1);
      end
      if (start && sending) begin
        overrunD = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= IDLE;
      rowQ      <= '0;
      bufQ      <= '0;
      accClearQ <= 1'b0;
      overrunQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      rowQ      <= rowD;
      bufQ      <= bufD;
      accClearQ <= accClearD;
      overrunQ  <= overrunD;
    end
  end

  // Stream outputs are gated by the state so reset zeroes them at once.
  assign acc_clear = accClearQ;
  assign overrun   = overrunQ;
  assign busy      = sending;
  assign out_valid = sending;
  assign out_data  = sending ? rowData : '0;
  assign out_row   = sending ? rowQ : '0;
  assign out_last  = sending & atLastRow;

endmodule

// File: tb/tb_systolic_drain.sv
// Testbench for systolic_drain, built with OUT_WIDTH=16 so saturation is
// exercised alongside ordinary streaming. Expected rows are queued when a
// start is driven and compared against every valid beat, stalled or not.
module tb_systolic_drain;

  localparam int SIZE = 8;
  localparam int RW   = 32;
  localparam int OW   = 16;
  localparam int DW   = SIZE*OW;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [SIZE*SIZE*RW-1:0] res_in;
  logic                   acc_clear;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic [2:0]             out_row;
  logic                   out_last;
  logic                   overrun;

  typedef struct {
    int            row;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  beat_t       expQ[$];
  int          assertCount = 0;
  int          failCount   = 0;
  int          xferCount   = 0;
  logic [31:0] resMat[SIZE][SIZE];

  systolic_drain #(.SIZE(SIZE), .RESULT_WIDTH(RW), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_in    (res_in),
    .acc_clear (acc_clear),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .overrun   (overrun)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".busy"},     DW'(busy),      '0);
    checkOutput({tag, ".valid"},    DW'(out_valid), '0);
    checkOutput({tag, ".accClear"}, DW'(acc_clear), '0);
    checkOutput({tag, ".overrun"},  DW'(overrun),   '0);
    checkOutput({tag, ".row"},      DW'(out_row),   '0);
    checkOutput({tag, ".data"},     out_data,       '0);
    checkOutput({tag, ".last"},     DW'(out_last),  '0);
  endtask

  // Queue the expected saturated rows of the current resMat.
  task automatic pushRows();
    beat_t       b;
    logic [31:0] v;
    for (int r = 0; r < SIZE; r++) begin
      b.row  = r;
      b.data = '0;
      b.last = (r == SIZE-1);
      for (int c = 0; c < SIZE; c++) begin
        v = resMat[r][c];
        b.data[c*OW +: OW] = (v > 32'd65535) ? 16'hFFFF : v[15:0];
      end
      expQ.push_back(b);
    end
  endtask

  // Drive resMat onto res_in and pulse start for one sampled edge.
  task automatic applyStimulus(input bit expectAccept);
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        res_in[(i*SIZE+j)*RW +: RW] = resMat[i][j];
    start = 1'b1;
    if (expectAccept) pushRows();
    waitCycles(1);
    start = 1'b0;
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while (busy && cycles < 300) begin
      waitCycles(1);
      cycles++;
    end
    checkOutput("drainDone",  DW'(busy), '0);
    checkOutput("queueEmpty", DW'(expQ.size()), '0);
  endtask

  // Scoreboard: every valid beat must match the queue head; a beat leaves
  // the queue only when the consumer accepts it.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      checkOutput("beatPending", DW'(expQ.size() > 0), DW'(1));
      if (expQ.size() > 0) begin
        checkOutput("outRow",  DW'(out_row),  DW'(expQ[0].row));
        checkOutput("outData", out_data,      expQ[0].data);
        checkOutput("outLast", DW'(out_last), DW'(expQ[0].last));
        if (out_ready === 1'b1) begin
          void'(expQ.pop_front());
          xferCount++;
        end
      end
    end
  end

  initial begin
    int cyc;
    int xferBase;

    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    res_in    = '0;
    #2;
    checkAllZero("reset");
    waitCycles(2);
    rst = 1'b1;
    waitCycles(1);

    // Diagonal snapshot with the consumer always ready.
    $display("[TB] diagonal snapshot");
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = (i == j) ? 32'd2 : 32'd0;
    out_ready = 1'b1;
    applyStimulus(1'b1);
    checkOutput("diag.accClearHigh", DW'(acc_clear), DW'(1));
    checkOutput("diag.busy",         DW'(busy),      DW'(1));
    checkOutput("diag.firstRow",     DW'(out_row),   '0);
    waitCycles(1);
    checkOutput("diag.accClearLow",  DW'(acc_clear), '0);
    drain(cyc);
    checkOutput("diag.streamCycles", DW'(cyc + 1), DW'(8));
    checkOutput("diag.noOverrun",    DW'(overrun), '0);

    // Same matrix under backpressure: ready pattern 1,0,0 repeating.
    $display("[TB] backpressure");
    xferBase = xferCount;
    applyStimulus(1'b1);
    for (int i = 0; i < 300 && busy; i++) begin
      out_ready = (i % 3 == 0);
      waitCycles(1);
    end
    out_ready = 1'b1;
    checkOutput("bp.idle",      DW'(busy), '0);
    checkOutput("bp.transfers", DW'(xferCount - xferBase), DW'(8));
    checkOutput("bp.queue",     DW'(expQ.size()), '0);

    // Saturation to 16 bits.
    $display("[TB] saturation");
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = 32'(i*1000 + j*7);
    resMat[3][5] = 32'd70000;
    resMat[3][6] = 32'd65535;
    resMat[6][0] = 32'hFFFF_FFFF;
    applyStimulus(1'b1);
    drain(cyc);

    // Dropped start mid-stream, then a start on the final beat.
    $display("[TB] overrun and back-to-back");
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = 32'(i*SIZE + j + 1);
    applyStimulus(1'b1);
    waitCycles(2);
    checkOutput("ovr.atRow2", DW'(out_row), DW'(2));
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = 32'd40000;
    applyStimulus(1'b0);
    checkOutput("ovr.flag",     DW'(overrun),   DW'(1));
    checkOutput("ovr.noClear",  DW'(acc_clear), '0);
    waitCycles(4);
    checkOutput("b2b.atLast",   DW'(out_last),  DW'(1));
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = 32'(500 + i*16 + j);
    applyStimulus(1'b1);
    checkOutput("b2b.valid",    DW'(out_valid), DW'(1));
    checkOutput("b2b.row0",     DW'(out_row),   '0);
    checkOutput("b2b.accClear", DW'(acc_clear), DW'(1));
    waitCycles(1);
    checkOutput("b2b.accClearLow", DW'(acc_clear), '0);
    drain(cyc);
    checkOutput("b2b.overrunSticky", DW'(overrun), DW'(1));

    // Reset asserted mid-stream while the consumer stalls on row 4.
    $display("[TB] reset mid-operation");
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        resMat[i][j] = 32'(i + j);
    applyStimulus(1'b1);
    waitCycles(4);
    out_ready = 1'b0;
    checkOutput("rst.atRow4", DW'(out_row), DW'(4));
    #3;
    rst = 1'b0;
    expQ.delete();
    #1;
    checkAllZero("rstAsync");
    waitCycles(1);
    checkAllZero("rstHeld");
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      waitCycles(1);
      checkOutput("rst.noBeat", DW'(out_valid), '0);
    end

    // A fresh start after reset streams normally.
    applyStimulus(1'b1);
    drain(cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output end of the systolic matrix-multiply path. When the array signals a finished computation, this block snapshots the full SIZE x SIZE accumulator matrix in one cycle and pulses a clear to the array accumulators.
- It then streams the snapshot out one row per beat over a valid/ready interface to the downstream consumer (writeback/DMA), saturating each element to OUT_WIDTH.

Parameters:
- SIZE, 8, array dimension (rows = cols).
- RESULT_WIDTH, 32, width of each array accumulator, unsigned.
- OUT_WIDTH, 32, width of each streamed element; must be 1..RESULT_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse: array results are final.
- res_in  in  SIZE*SIZE*RESULT_WIDTH  flattened accumulators; element [i][j] at bits ((i*SIZE+j)*RESULT_WIDTH) +: RESULT_WIDTH.
- acc_clear  out  1  one-cycle pulse to clear array accumulators.
- busy  out  1  high while a matrix is held or streaming.
- out_valid  out  1  row beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  SIZE*OUT_WIDTH  row elements; column j at bits (j*OUT_WIDTH) +: OUT_WIDTH.
- out_row  out  $clog2(SIZE)  index of the row on out_data.
- out_last  out  1  high with row SIZE-1.
- overrun  out  1  sticky: a start was dropped.

Behaviour:
- Reset (rst=0, asynchronous) forces the following, regardless of state, including mid-stream:
  - state=IDLE and the row counter to 0.
  - The snapshot buffer to all zeros.
  - acc_clear, busy, out_valid, out_last and overrun to 0.
  - out_row and out_data to 0.
- Two states:
  - IDLE: busy=0, out_valid=0.
  - SEND: busy=1, out_valid=1.
- Accept condition: start is accepted when state==IDLE, or when state==SEND and the final beat (out_last & out_valid & out_ready) completes in the same cycle.
- On an accepted start at edge t:
  - The snapshot buffer loads res_in, with saturation applied.
  - The row counter is set to 0 and the state becomes SEND.
  - acc_clear is registered high for exactly the cycle following t.
- Latency: first beat is valid in the cycle after the accepting edge. A start held high for several cycles counts once per cycle it is sampled.
- Saturation, per element: if the value exceeds 2^OUT_WIDTH-1, the output is 2^OUT_WIDTH-1; otherwise it is the low OUT_WIDTH bits. When OUT_WIDTH==RESULT_WIDTH this is a pass-through.
- SEND outputs:
  - out_data = buffer row[row counter].
  - out_row = row counter.
  - out_last = (row counter == SIZE-1).
- Handshake:
  - A beat transfers on a rising edge with out_valid & out_ready; the row counter then increments.
  - While out_valid & !out_ready, out_data, out_row and out_last hold stable.
  - out_valid never drops before its beat transfers.
- Final beat transfer: the state returns to IDLE, unless a start is accepted in the same cycle, in which case the state stays SEND with row 0 of the new snapshot (back-to-back, no bubble).
- Overrun: a start in SEND that is not on a final-beat transfer cycle is dropped. It sets overrun (sticky until reset) and does not disturb the buffer, the counter or acc_clear.
- out_ready is ignored in IDLE.
- SIZE=1: a single beat with out_last=1.

Test Plan:
- Diagonal snapshot: res_in = 2 on the diagonal and 0 elsewhere (SIZE=8), out_ready=1, one start pulse.
  - acc_clear high for 1 cycle.
  - 8 consecutive beats, out_row 0..7; row r has element r = 2 and the rest 0.
  - out_last only on row 7; busy falls the cycle after.
- Backpressure: same input, out_ready toggled 1,0,0,1,...
  - Beats stall with out_data, out_row and out_last unchanged while ready=0.
  - Exactly 8 transfers, no duplicated or skipped rows.
- Saturation: OUT_WIDTH=16, element [3][5]=70000 and [3][6]=65535.
  - Row 3 delivers 65535 at column 5 and 65535 at column 6; other elements pass through unchanged.
- Overrun and back-to-back: start at row 2 of an active stream, then start again coincident with the final beat.
  - First start sets overrun=1 and the stream continues unchanged.
  - Second start is accepted: the next cycle shows row 0 of the new res_in with out_valid=1 and one acc_clear pulse.
- Reset mid-operation: assert rst=0 during row 4 while out_ready=0.
  - All outputs go to 0 immediately (asynchronously) and overrun clears.
  - After release, no beat is issued until a new start.
